// File: rtl/run_length_classifier.sv
// Serial run-length classifier: measures each run of consecutive 1s on x_in
// and emits a one-cycle registered code on OUT.
//   00 none, 01 short run ended, 10 medium run ended, 11 long run reached.
// A long run is reported once, at the moment it reaches LONG_LEN. Its
// eventual end produces no further pulse.
module run_length_classifier #(
  parameter int unsigned SHORT_LEN = 2,
  parameter int unsigned LONG_LEN  = 5,
  parameter int unsigned CNT_W     = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       x_in,
  output logic [1:0] OUT
);

  localparam logic [1:0] OutNone   = 2'b00;
  localparam logic [1:0] OutShort  = 2'b01;
  localparam logic [1:0] OutMedium = 2'b10;
  localparam logic [1:0] OutLong   = 2'b11;

  localparam logic [CNT_W-1:0] ShortLen = CNT_W'(SHORT_LEN);
  localparam logic [CNT_W-1:0] LongLen  = CNT_W'(LONG_LEN);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  typedef enum logic [1:0] {
    StZero = 2'd0,
    StOnes = 2'd1,
    StLong = 2'd2
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] cnt_inc;

  // Length the current run would have if this edge samples another 1.
  assign cnt_inc = run_cnt + CntOne;

  // Run tracking FSM with registered classification pulse.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state   <= StZero;
      run_cnt <= '0;
      OUT     <= OutNone;
    end else begin
      OUT <= OutNone;
      unique case (state)
        StZero: begin
          if (x_in) begin
            run_cnt <= CntOne;
            if (LongLen == CntOne) begin
              state <= StLong;
              OUT   <= OutLong;
            end else begin
              state <= StOnes;
            end
          end else begin
            run_cnt <= '0;
          end
        end
        StOnes: begin
          if (x_in) begin
            run_cnt <= cnt_inc;
            if (cnt_inc == LongLen) begin
              state <= StLong;
              OUT   <= OutLong;
            end
          end else begin
            // run_cnt still holds the finished run's length here.
            state   <= StZero;
            run_cnt <= '0;
            OUT     <= (run_cnt <= ShortLen) ? OutShort : OutMedium;
          end
        end
        StLong: begin
          if (x_in) begin
            // Saturate: the counter never moves past LONG_LEN.
            run_cnt <= LongLen;
          end else begin
            state   <= StZero;
            run_cnt <= '0;
          end
        end
        default: begin
          state   <= StZero;
          run_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/run_length_classifier.md
Name: run_length_classifier

Overview:
- Serial-input receiver FSM that consumes the single-bit stream `x_in` driven by the HW3 pattern bench.
- It measures each run of consecutive 1s and reports a 2-bit classification code on `OUT`.
- It is the DUT end of the bench's `CLK`/`reset`/`x_in`/`OUT` interface: the bench drives, this block detects and classifies.
- It is purely sequential, with a registered output.

Parameters:
- SHORT_LEN, 2: longest run of 1s classified as "short".
- LONG_LEN, 5: run length at which a run is declared "long".
- CNT_W, 4: run-counter width.
- Legal range: 1 <= SHORT_LEN < LONG_LEN <= 2^CNT_W - 1.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- x_in  input  1  serial data; sampled on the rising edge of CLK.
- OUT  output  2  registered classification code: 00 none, 01 short run ended, 10 medium run ended, 11 long run reached.

Behaviour:
- Reset (`reset`=0, asynchronous):
  - state=ZERO, run_cnt=0, OUT=2'b00, immediately and held while asserted.
  - Release is sampled synchronously: the first edge with `reset`=1 operates normally.
- States:
  - ZERO: last sample was 0, or out of reset.
  - ONES: inside a run, run_cnt < LONG_LEN.
  - LONG: inside a run that has reached LONG_LEN.
- Run counting: each rising edge that samples `x_in`=1 while in ZERO or ONES increments run_cnt. A run's length L is the number of consecutive 1 samples.
- Transitions and outputs at each rising edge (OUT defaults to 00 unless listed):
  - ZERO, x_in=0: stay ZERO, run_cnt=0.
  - ZERO, x_in=1: run_cnt=1. If LONG_LEN==1, go to LONG with OUT=11; otherwise go to ONES.
  - ONES, x_in=1: run_cnt+1. If the new count == LONG_LEN, go to LONG with OUT=11 for this one cycle; otherwise stay ONES.
  - ONES, x_in=0: go to ZERO, run_cnt=0. OUT=01 if L <= SHORT_LEN, else OUT=10.
  - LONG, x_in=1: stay LONG. run_cnt frozen at LONG_LEN (never wraps); OUT=00.
  - LONG, x_in=0: go to ZERO, run_cnt=0, OUT=00 (the long run was already reported).
- Pulse and latency rules:
  - OUT is a one-cycle pulse. It is valid from the rising edge that samples the deciding bit until the next rising edge.
  - Latency is 1 edge from the deciding sample to OUT visible; there is no combinational path from `x_in` to OUT.
  - Back-to-back events are legal. A run terminating edge can be followed by a new run start on the next edge.
  - A single 1 (L=1) yields 01 when SHORT_LEN >= 1.
- Width and arithmetic: run_cnt is CNT_W bits, unsigned. Comparisons against SHORT_LEN and LONG_LEN are unsigned. No overflow is possible because counting stops at LONG_LEN.
- Reset mid-run: any pending classification is discarded, with no pulse emitted. After release, the first 1 starts a fresh run at L=1.
- Unknown `x_in` (X/Z) is not supported. The bench must drive 0 or 1 at every sampling edge.

Test Plan:
- Reset, then x_in=0 for 4 edges -> OUT=00 throughout; state ZERO.
- Reset release, x_in=1 for 6 edges then 0 -> OUT=11 for exactly one cycle after the 5th 1 sample, OUT=00 at the run-ending edge and elsewhere.
- x_in pattern 0,1,0,1,1,0 -> OUT=01 after the 1st 0-after-1 (L=1), OUT=01 after the run L=2. No 10 or 11.
- x_in pattern 1,1,1,1,0 (L=4) -> single OUT=10 pulse at the terminating 0; never 11.
- Full bench sequence: reset pulse, 1 x6, 0 x4, 1 x4, end -> exactly one 11 pulse. No pulse for the trailing open run of 4; run_cnt=4 in ONES at end.
- Drive `reset`=0 asynchronously mid-cycle during a run of 3 -> OUT=00 and run_cnt=0 immediately without waiting for an edge. After release, run 1,0 -> OUT=01.
